// File: rtl/light_sequencer.sv
// light_sequencer
// ---------------------------------------------------------------------------
// Traffic-light phase controller. Sequences main street, side street and
// pedestrian lamps through the phases MG -> MY -> (WALK) -> SG -> SY -> MG.
// Each phase runs for a programmable interval counted in timing ticks. A tick
// is produced by a prescaler every TICK_DIV clock cycles. All lamp outputs are
// decoded from the state register only (Moore).
//
// Optional feature macro: WALK_PHASE_EN
//   defined   : walk-request latch and WALK phase are present.
//   undefined : no WALK phase, WR_Sync ignored, Walk_Light tied to 0.
//
// Ports
//   clk          in   system clock, rising edge
//   Reset        in   synchronous active-high reset
//   Sensor_Sync  in   side-street vehicle present (extends SG once)
//   WR_Sync      in   pedestrian walk request (level or pulse)
//   Prog_Sync    in   reprogram strobe; forces MG start while high
//   Sel[1:0]     in   interval select: 0 base, 1 ext, 2 yellow, 3 none
//   Value[3:0]   in   interval value in ticks (0 is stored as 1)
//   Main_Light   out  {R,Y,G} one-hot
//   Side_Light   out  {R,Y,G} one-hot
//   Walk_Light   out  pedestrian walk lamp
//   o_dbg_state  out  raw state register for observation
//
// Handshake: there is no valid/ready pairing here; every input is a level
// sampled on each rising clk edge and acted on at that same edge.
// ---------------------------------------------------------------------------
module light_sequencer #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int T_BASE_DEF = 6,
  parameter int T_EXT_DEF  = 3,
  parameter int T_YEL_DEF  = 2
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Sensor_Sync,
  input  logic       WR_Sync,
  input  logic       Prog_Sync,
  input  logic [1:0] Sel,
  input  logic [3:0] Value,
  output logic [2:0] Main_Light,
  output logic [2:0] Side_Light,
  output logic       Walk_Light,
  output logic [2:0] o_dbg_state
);

  localparam logic [2:0] ST_MG   = 3'd0;
  localparam logic [2:0] ST_MY   = 3'd1;
  localparam logic [2:0] ST_WALK = 3'd2;
  localparam logic [2:0] ST_SG   = 3'd3;
  localparam logic [2:0] ST_SY   = 3'd4;

  // Prescaler width; a TICK_DIV of 1 still needs a one-bit register.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [2:0]    r_state;
  logic [3:0]    r_remain;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_t_base;
  logic [3:0]    r_t_ext;
  logic [3:0]    r_t_yel;
  logic          r_ext_flag;

  logic          w_tick;
  logic          w_expire;
  logic          w_walk_pending;
  logic [2:0]    w_next_state;
  logic          w_reload;
  logic [3:0]    w_reload_val;
  logic          w_set_ext;
  logic          w_enter_sg;
  logic [3:0]    w_prog_val;

  assign w_tick     = (r_presc == PRESC_MAX);
  assign w_expire   = w_tick && (r_remain == 4'd1);
  assign w_prog_val = (Value == 4'd0) ? 4'd1 : Value;
  // Extension reload keeps r_state at SG, so only a real transition counts.
  assign w_enter_sg = w_reload && (w_next_state == ST_SG) && (r_state != ST_SG);

`ifdef WALK_PHASE_EN
  logic r_walk_latch;
  assign w_walk_pending = r_walk_latch;

  // Entry into WALK clears the latch and wins over a same-cycle request.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_walk_latch <= 1'b0;
    end else if (!Prog_Sync && w_reload && (w_next_state == ST_WALK)) begin
      r_walk_latch <= 1'b0;
    end else if (WR_Sync) begin
      r_walk_latch <= 1'b1;
    end
  end
`else
  logic w_unused_wr;
  assign w_unused_wr    = WR_Sync;
  assign w_walk_pending = 1'b0;
`endif

  // Next state and interval to load when the current phase expires.
  always_comb begin
    w_next_state = r_state;
    w_reload     = 1'b0;
    w_reload_val = r_remain;
    w_set_ext    = 1'b0;
    if (w_expire) begin
      w_reload = 1'b1;
      case (r_state)
        ST_MG: begin
          w_next_state = ST_MY;
          w_reload_val = r_t_yel;
        end
        ST_MY: begin
          if (w_walk_pending) begin
            w_next_state = ST_WALK;
            w_reload_val = r_t_ext;
          end else begin
            w_next_state = ST_SG;
            w_reload_val = r_t_base;
          end
        end
        ST_WALK: begin
          w_next_state = ST_SG;
          w_reload_val = r_t_base;
        end
        ST_SG: begin
          if (Sensor_Sync && !r_ext_flag) begin
            w_set_ext    = 1'b1;
            w_reload_val = r_t_ext;
          end else begin
            w_next_state = ST_SY;
            w_reload_val = r_t_yel;
          end
        end
        ST_SY: begin
          w_next_state = ST_MG;
          w_reload_val = r_t_base;
        end
        default: begin
          w_next_state = ST_MG;
          w_reload_val = r_t_base;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state    <= ST_MG;
      r_t_base   <= 4'(T_BASE_DEF);
      r_t_ext    <= 4'(T_EXT_DEF);
      r_t_yel    <= 4'(T_YEL_DEF);
      r_ext_flag <= 1'b0;
      r_presc    <= '0;
      r_remain   <= 4'(T_BASE_DEF);
    end else if (Prog_Sync) begin
      case (Sel)
        2'd0:    r_t_base <= w_prog_val;
        2'd1:    r_t_ext  <= w_prog_val;
        2'd2:    r_t_yel  <= w_prog_val;
        default: ;
      endcase
      r_state  <= ST_MG;
      r_presc  <= '0;
      // MG restarts with the base interval as it stands after this write.
      r_remain <= (Sel == 2'd0) ? w_prog_val : r_t_base;
    end else begin
      r_state <= w_next_state;
      if (w_reload) begin
        r_remain <= w_reload_val;
        r_presc  <= '0;
      end else if (w_tick) begin
        r_remain <= r_remain - 4'd1;
        r_presc  <= '0;
      end else begin
        r_presc  <= r_presc + 1'b1;
      end
      if (w_set_ext) begin
        r_ext_flag <= 1'b1;
      end else if (w_enter_sg) begin
        r_ext_flag <= 1'b0;
      end
    end
  end

  // Lamp decode from state only.
  always_comb begin
    Main_Light = 3'b100;
    Side_Light = 3'b100;
    Walk_Light = 1'b0;
    case (r_state)
      ST_MG: Main_Light = 3'b001;
      ST_MY: Main_Light = 3'b010;
      ST_SG: Side_Light = 3'b001;
      ST_SY: Side_Light = 3'b010;
`ifdef WALK_PHASE_EN
      ST_WALK: Walk_Light = 1'b1;
`endif
      default: ;
    endcase
  end

  assign o_dbg_state = r_state;

endmodule

// File: doc/light_sequencer.md
# light_sequencer

Traffic-light phase controller for the intersection. It sits directly after the input synchronizer and consumes its synchronized Sensor, Walk Request and Reprogram signals. It sequences main-street, side-street and pedestrian lights through fixed phases using a programmable per-phase interval table and a second-tick prescaler. All outputs are Moore outputs, decoded from the state register only.

## Interface
- TICK_DIV, 100_000_000: clk cycles per timing tick (1 s at 100 MHz); at least 1.
- T_BASE_DEF, 6: reset value of the base interval, in ticks.
- T_EXT_DEF, 3: reset value of the extension/walk interval, in ticks.
- T_YEL_DEF, 2: reset value of the yellow interval, in ticks.
- clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset (the synchronizer's Reset_Sync).
- Sensor_Sync  in  1  side-street vehicle present.
- WR_Sync  in  1  pedestrian walk request; level or pulse.
- Prog_Sync  in  1  reprogram strobe.
- Sel  in  2  interval select during reprogram: 0 base, 1 ext, 2 yellow, 3 ignored.
- Value  in  4  interval value during reprogram, in ticks.
- Main_Light  out  3  {R,Y,G}, one-hot.
- Side_Light  out  3  {R,Y,G}, one-hot.
- Walk_Light  out  1  pedestrian walk lamp.

## Operation
- States and decoded outputs:
  - MG: main green, side red.
  - MY: main yellow, side red.
  - WALK: both red, Walk_Light=1.
  - SG: main red, side green.
  - SY: main red, side yellow.
- Durations and transitions:
  - MG runs T_BASE, then goes to MY.
  - MY runs T_YEL, then goes to WALK if the walk latch is set, else to SG.
  - WALK runs T_EXT, then goes to SG.
  - SG runs T_BASE, then goes to SY. If Sensor_Sync=1 on SG's expiry cycle and the extension flag is clear, SG instead reloads T_EXT, sets the flag and stays in SG. At most one extension per SG visit. The flag clears on SG entry.
  - SY runs T_YEL, then goes to MG.
- Timer:
  - The 4-bit remaining count loads the state's interval on state entry.
  - The prescaler (0..TICK_DIV-1) is zeroed on state entry.
  - A tick occurs when the prescaler equals TICK_DIV-1.
  - On a tick, remaining decrements. Expiry is a tick with remaining==1.
  - Each phase therefore lasts exactly interval×TICK_DIV cycles.
- Walk latch:
  - Set on any cycle with WR_Sync=1.
  - Cleared on entry to WALK. If set and clear coincide, clear wins; that request is served by the current WALK.
- Reprogram:
  - When Prog_Sync=1, Value is written to the interval register selected by Sel. A Value of 0 is stored as 1.
  - The state is forced to MG and the timer and prescaler are reloaded.
  - The walk latch and the extension flag are kept.
  - While Prog_Sync is held, the block writes every cycle and stays at the start of MG. Sequencing resumes on the cycle after Prog_Sync falls.
- Priority: Reset, then Prog_Sync, then normal sequencing.
- Reset values:
  - State MG, so Main_Light=3'b001, Side_Light=3'b100, Walk_Light=0.
  - Intervals return to their *_DEF values.
  - Walk latch and extension flag cleared; prescaler and timer reloaded for MG.

## Timing
- Input to state reaction latency is one clk edge. Outputs change in the same cycle as the state register.
- A reset applied mid-phase takes effect at the next edge and does not wait for the phase to finish.
- The phase period with defaults and no requests is (6+2+6+2)×TICK_DIV cycles.

## Configuration
- WALK_PHASE_EN defined:
  - The walk latch and the WALK state exist as described above.
- WALK_PHASE_EN undefined:
  - No latch and no WALK state; MY always goes to SG.
  - WR_Sync is ignored and Walk_Light is constant 0.
  - T_EXT is used only for the SG extension.

## Test plan
All scenarios use TICK_DIV=2 and default intervals.
- Reset, then free-run with no requests -> MG 12 cycles, MY 4, SG 12, SY 4, back to MG; period 32 cycles; post-reset Main_Light=001, Side_Light=100.
- Sensor_Sync held 1 -> SG lasts 18 cycles (one extension only); period 38 cycles.
- 1-cycle WR_Sync pulse mid-MG -> after MY, WALK for 6 cycles with Main=Side=100 and Walk_Light=1, then SG; the next cycle has no WALK.
- Prog_Sync with Sel=2, Value=5 during SG -> MG on the next cycle with the full 12-cycle MG; subsequent yellows last 10 cycles.
- Prog_Sync with Sel=0, Value=0 -> MG and SG last 2 cycles each; a Reset asserted mid-SY -> MG on the next cycle and the base interval back to 12 cycles.
- Built without WALK_PHASE_EN, WR_Sync held 1 -> no WALK phase, Walk_Light stays 0, period 32 cycles.
